// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline load/store unit with read-modify-write sub-word stores and sign-extending loads.
// Defining MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES cycles of mem_ready low in a wait state.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        mem_ready
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_word, r_rdata;
    logic [1:0]  r_size;
    logic        r_signed, r_store, r_err;
    logic        w_accept, w_bad, w_wait, w_timeout;
    logic [4:0]  w_sh;
    logic [15:0] w_lane;
    logic [31:0] w_mask, w_merge, w_load;

    assign w_accept = req_valid && req_ready;
    assign w_bad = (req_load == req_store) || (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    assign w_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);
    // Little-endian byte lane selected by the low address bits
    assign w_sh = {r_addr[1:0], 3'b000};
    assign w_lane = 16'(read_data >> w_sh);
    assign w_mask = (r_size == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merge = (read_data & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    assign w_load = r_size == 2'd0 ? {{24{r_signed & w_lane[7]}}, w_lane[7:0]} :
                    r_size == 2'd1 ? {{16{r_signed & w_lane[15]}}, w_lane} : read_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_cnt <= '0;
        else       r_cnt <= (w_wait && !mem_ready) ? r_cnt + CW'(1) : '0;

    assign w_timeout = w_wait && !mem_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next     = r_state;
        req_ready  = (r_state == IDLE) && !reset;
        resp_valid = r_state == RESP;
        mem_read   = r_state == RD;
        mem_write  = r_state == WR;
        case (r_state)
            IDLE:    w_next = !w_accept ? IDLE : w_bad ? RESP : (req_store && req_size == 2'd2) ? WR : RD;
            RD:      w_next = RD_WAIT;
            RD_WAIT: w_next = mem_ready ? (r_store ? WR : RESP) : w_timeout ? RESP : RD_WAIT;
            WR:      w_next = WR_WAIT;
            WR_WAIT: w_next = (mem_ready || w_timeout) ? RESP : WR_WAIT;
            default: w_next = IDLE;
        endcase
    end

    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = r_rdata;
    assign address    = (r_state inside {RD, RD_WAIT, WR, WR_WAIT}) ? {r_addr[31:2], 2'b00} : '0;
    assign write_data = (r_state inside {WR, WR_WAIT}) ? r_word : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_word   <= req_wdata;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_store  <= req_store;
            end
            if (r_state == RD_WAIT && mem_ready && r_store) r_word <= w_merge;
            // Result and error are fixed on the edge into RESP and held until the next response
            if (w_next == RESP) begin
                r_err   <= (r_state == IDLE) || w_timeout;
                r_rdata <= (r_state == RD_WAIT && mem_ready && !r_store) ? w_load : '0;
            end
        end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, address, write_data;
    logic [31:0] read_data = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] mem [0:63];
    int          checks = 0, errors = 0;

    typedef struct {
        logic        ld, st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr, wdata, rdata;
        logic        err;
        int          lat, rd, wr;
    } vec_t;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write), .address(address),
        .write_data(write_data), .read_data(read_data), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            mem[8] <= 32'h11223344;
            mem[9] <= 32'h8000AAAA;
        end else begin
            if (mem_read)  read_data <= mem[address[7:2]];
            if (mem_write) mem[address[7:2]] <= write_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one request; mem_ready is held low from accept until wait cycle 'stall' when stall > 0
    task automatic do_req(input vec_t t, input int stall, input string nm);
        int k, rd, wr, excl, lat;
        logic [31:0] a;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_load = t.ld; req_store = t.st; req_size = t.sz;
        req_signed = t.sg; req_addr = t.addr; req_wdata = t.wdata;
        if (stall > 0) mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_load = ~t.ld; req_store = ~t.st; req_size = 2'd3;
        req_signed = ~t.sg; req_addr = ~t.addr; req_wdata = 32'h0;
        k = 1; rd = 0; wr = 0; excl = 0; lat = -1; a = '0;
        while (lat < 0 && k <= 40) begin
            rd += int'(mem_read);
            wr += int'(mem_write);
            if (mem_read && mem_write) excl++;
            if (mem_read || mem_write) a = address;
            if (resp_valid) lat = k;
            else begin
                if (k == stall) mem_ready = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        mem_ready = 1'b1;
        chk({nm, ".lat"}, 32'(lat), 32'(t.lat));
        chk({nm, ".rdata"}, resp_rdata, t.rdata);
        chk({nm, ".err"}, 32'(resp_err), 32'(t.err));
        chk({nm, ".rd"}, 32'(rd), 32'(t.rd));
        chk({nm, ".wr"}, 32'(wr), 32'(t.wr));
        chk({nm, ".excl"}, 32'(excl), 32'd0);
        if (t.rd + t.wr > 0) chk({nm, ".addr"}, a, {t.addr[31:2], 2'b00});
    endtask

    initial begin
        vec_t v[18];
        vec_t s;
        int n;
        v[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3, 0, 1};
        v[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0};
        v[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        32'h00000011, 1'b0, 3, 1, 0};
        v[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h26, 32'h0,        32'hFFFF8000, 1'b0, 3, 1, 0};
        v[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h26, 32'h0,        32'h00008000, 1'b0, 3, 1, 0};
        v[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h24, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 1, 0};
        v[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h25, 32'h0,        32'h000000AA, 1'b0, 3, 1, 0};
        v[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF55, 32'h0,        1'b0, 5, 1, 1};
        v[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h11225544, 1'b0, 3, 1, 0};
        v[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF, 32'h0,        1'b0, 5, 1, 1};
        v[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'hBEEF5544, 1'b0, 3, 1, 0};
        v[11] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'h0,        1'b1, 1, 0, 0};
        v[12] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0};
        v[13] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0};
        v[14] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0};
        v[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 32'h0,        1'b1, 1, 0, 0};
        v[16] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000ABCD, 32'h0,        1'b1, 1, 0, 0};
        v[17] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        32'h000000BE, 1'b0, 3, 1, 0};

        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.mem_read", 32'(mem_read), 32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.address", address, 32'd0);
        chk("rst.write_data", write_data, 32'd0);
        reset = 1'b0;
        #1 chk("rst.release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 18; i++) do_req(v[i], 0, $sformatf("vec%0d", i));

        repeat (2) @(negedge clk);
        chk("hold.rdata", resp_rdata, 32'h000000BE);
        chk("hold.err", 32'(resp_err), 32'd0);

        s = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 1, 0};
        do_req(s, 4, "stall_lw");
        s = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h00000077, 32'h0, 1'b0, 6, 1, 1};
        do_req(s, 3, "stall_sb");
        s = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'h0BADF00D, 32'h0, 1'b0, 5, 0, 1};
        do_req(s, 4, "stall_sw");
        s = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h0BADF00D, 1'b0, 3, 1, 0};
        do_req(s, 0, "rb_sw");
        s = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBE77, 1'b0, 3, 1, 0};
        do_req(s, 0, "rb_sb");

        // Reset while the load sits in RD_WAIT
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst.resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst.req_ready", 32'(req_ready), 32'd0);
        chk("midrst.address", address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midrst.ready_after", 32'(req_ready), 32'd1);
        mem_ready = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(resp_valid);
        end
        chk("midrst.no_resp", 32'(n), 32'd0);

`ifdef MEM_TIMEOUT_EN
        s = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 18, 1, 0};
        do_req(s, 1000, "to_lw");
        s = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h00000099, 32'h0, 1'b1, 18, 1, 0};
        do_req(s, 1000, "to_sb");
        s = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBE77, 1'b0, 3, 1, 0};
        do_req(s, 0, "to_rb");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
